// File: rtl/scroll_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : scroll_ptr_unit
// Brief    : Multi-layer background scroll pointer generator. Each layer has a
//            frame prescaler and a wrapping pointer, which gives parallax scrolling.
//            Optional macro SCROLL_REVERSE_EN enables reverse (decrement) scrolling.
// Revision : 1.0 - initial release
// ============================================================================
module scroll_ptr_unit #(
  parameter int PTR_W  = 13,
  parameter int LAYERS = 2,
  parameter int DIV_W  = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ScrollEnable,
  input  logic                     FrameTick,
  input  logic                     Direction,
  input  logic [LAYERS*DIV_W-1:0]  LayerDiv,
  input  logic [PTR_W-1:0]         PtrLimit,
  input  logic                     Load,
  input  logic [PTR_W-1:0]         LoadValue,
  output logic [LAYERS*PTR_W-1:0]  FramePtr,
  output logic [LAYERS-1:0]        Wrap
);

  logic             tick_en;
  logic [PTR_W-1:0] load_ptr;

  assign tick_en  = FrameTick & ScrollEnable;
  // A load never places a pointer beyond the current wrap point.
  assign load_ptr = (LoadValue > PtrLimit) ? PtrLimit : LoadValue;

`ifndef SCROLL_REVERSE_EN
  logic unused_direction;
  assign unused_direction = Direction;
`endif

  for (genvar i = 0; i < LAYERS; i++) begin : g_layer
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_adv;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             adv_wrap;
    logic             wrap;

    assign div = LayerDiv[i*DIV_W +: DIV_W];

    // The wrap check happens before the increment, so the sum never needs a carry bit.
    always_comb begin
      ptr_adv  = ptr + PTR_W'(1);
      adv_wrap = 1'b0;
      if (ptr >= PtrLimit) begin
        ptr_adv  = '0;
        adv_wrap = 1'b1;
      end
`ifdef SCROLL_REVERSE_EN
      if (Direction) begin
        if ((ptr == '0) || (ptr > PtrLimit)) begin
          ptr_adv  = PtrLimit;
          adv_wrap = 1'b1;
        end else begin
          ptr_adv  = ptr - PTR_W'(1);
          adv_wrap = 1'b0;
        end
      end
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        ptr  <= '0;
        cnt  <= '0;
        wrap <= 1'b0;
      end else if (Load) begin
        ptr  <= load_ptr;
        cnt  <= '0;
        wrap <= 1'b0;
      end else if (tick_en) begin
        // The >= comparison still releases a count stranded above a lowered divisor.
        if (cnt >= div) begin
          cnt  <= '0;
          ptr  <= ptr_adv;
          wrap <= adv_wrap;
        end else begin
          cnt  <= cnt + DIV_W'(1);
          wrap <= 1'b0;
        end
      end else begin
        wrap <= 1'b0;
      end
    end

    assign FramePtr[i*PTR_W +: PTR_W] = ptr;
    assign Wrap[i]                    = wrap;
  end

endmodule
`default_nettype wire

// File: tb/tb_scroll_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_scroll_ptr_unit
// Brief    : Scoreboard bench for scroll_ptr_unit with directed and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scroll_ptr_unit;
  localparam int PTR_W  = 13;
  localparam int LAYERS = 2;
  localparam int DIV_W  = 4;

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic                    ScrollEnable;
  logic                    FrameTick;
  logic                    Direction;
  logic [LAYERS*DIV_W-1:0] LayerDiv;
  logic [PTR_W-1:0]        PtrLimit;
  logic                    Load;
  logic [PTR_W-1:0]        LoadValue;
  logic [LAYERS*PTR_W-1:0] FramePtr;
  logic [LAYERS-1:0]       Wrap;

  scroll_ptr_unit #(.PTR_W(PTR_W), .LAYERS(LAYERS), .DIV_W(DIV_W)) dut (
    .Clk(Clk), .Reset(Reset), .ScrollEnable(ScrollEnable), .FrameTick(FrameTick),
    .Direction(Direction), .LayerDiv(LayerDiv), .PtrLimit(PtrLimit), .Load(Load),
    .LoadValue(LoadValue), .FramePtr(FramePtr), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [LAYERS*PTR_W-1:0] fp;
    logic [LAYERS-1:0]       wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rst_drv  = 1'b0;

  // Reference state: plain integers per layer.
  int m_ptr[LAYERS];
  int m_cnt[LAYERS];
  int m_wrap[LAYERS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < LAYERS; i++) begin
      m_ptr[i] = 0; m_cnt[i] = 0; m_wrap[i] = 0;
    end
  endfunction

  task automatic step(input bit tick, input bit en, input bit dir, input bit ld,
                      input int lv, input int lim, input int d0, input int d1);
    int   divs[LAYERS];
    bit   rev;
    exp_t e;
    @(negedge Clk);
    Reset        = rst_drv;
    FrameTick    = tick;
    ScrollEnable = en;
    Direction    = dir;
    Load         = ld;
    LoadValue    = PTR_W'(lv);
    PtrLimit     = PTR_W'(lim);
    LayerDiv     = {DIV_W'(d1), DIV_W'(d0)};
    divs[0] = d0; divs[1] = d1;
`ifdef SCROLL_REVERSE_EN
    rev = dir;
`else
    rev = 1'b0;
`endif
    if (!rst_drv) model_reset();
    else if (ld) begin
      for (int i = 0; i < LAYERS; i++) begin
        m_ptr[i] = (lv < lim) ? lv : lim; m_cnt[i] = 0; m_wrap[i] = 0;
      end
    end else if (tick && en) begin
      for (int i = 0; i < LAYERS; i++) begin
        m_wrap[i] = 0;
        if (m_cnt[i] >= divs[i]) begin
          m_cnt[i] = 0;
          if (!rev) begin
            if (m_ptr[i] >= lim) begin m_ptr[i] = 0; m_wrap[i] = 1; end
            else m_ptr[i] = m_ptr[i] + 1;
          end else begin
            if (m_ptr[i] == 0 || m_ptr[i] > lim) begin m_ptr[i] = lim; m_wrap[i] = 1; end
            else m_ptr[i] = m_ptr[i] - 1;
          end
        end else m_cnt[i] = m_cnt[i] + 1;
      end
    end else begin
      for (int i = 0; i < LAYERS; i++) m_wrap[i] = 0;
    end
    for (int i = 0; i < LAYERS; i++) begin
      e.fp[i*PTR_W +: PTR_W] = PTR_W'(m_ptr[i]);
      e.wr[i]                = m_wrap[i][0];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle is an output beat; compare against the oldest expectation.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frame_ptr", 64'(FramePtr), 64'(e.fp));
      chk("wrap", 64'(Wrap), 64'(e.wr));
    end
  end

  task automatic mid_reset();
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_ptr", 64'(FramePtr), 64'd0);
    chk("async_reset_wrap", 64'(Wrap), 64'd0);
    rst_drv = 1'b0;
    step(1, 1, 0, 0, 0, 9, 0, 0);
    rst_drv = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; FrameTick = 0; ScrollEnable = 0; Direction = 0; Load = 0;
    LoadValue = '0; PtrLimit = 13'd9; LayerDiv = '0;
    model_reset();
    #2;
    chk("reset_ptr", 64'(FramePtr), 64'd0);
    chk("reset_wrap", 64'(Wrap), 64'd0);
    step(1, 1, 0, 0, 0, 9, 0, 0);
    rst_drv = 1'b1;

    // Forward wrap: 12 ticks through limit 9
    for (int k = 0; k < 12; k++) step(1, 1, 0, 0, 0, 9, 0, 0);
    // Parallax
    step(0, 1, 0, 1, 0, 100, 0, 3);
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 0, 100, 0, 3);
    // Freeze, then a single enabled tick
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 100, 0, 3);
    step(1, 1, 0, 0, 0, 100, 0, 3);
    step(0, 1, 0, 0, 0, 100, 0, 3);
    // Loads: clamped (with coincident tick) and in range
    step(1, 1, 0, 1, 20, 9, 0, 0);
    step(0, 1, 0, 1, 5, 9, 0, 0);
    // Reverse from 0
    step(0, 1, 0, 1, 0, 9, 0, 0);
    step(1, 1, 1, 0, 0, 9, 0, 0);
    step(1, 1, 1, 0, 0, 9, 0, 0);
    // Limit 0
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0, 1);
    // 30 ticks then asynchronous reset, then first tick after release
    for (int k = 0; k < 30; k++) step(1, 1, 0, 0, 0, 9, 0, 2);
    mid_reset();
    step(1, 1, 0, 0, 0, 9, 0, 0);

    // Randomized traffic
    begin
      int lim = 9;
      int d0 = 0;
      int d1 = 3;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 49) == 0) begin
          case ($urandom_range(0, 3))
            0: lim = 0;
            1: lim = (1 << PTR_W) - 1;
            2: lim = int'($urandom_range(1, 20));
            default: lim = int'($urandom_range(0, (1 << PTR_W) - 1));
          endcase
        end
        if ($urandom_range(0, 29) == 0) d0 = int'($urandom_range(0, 15));
        if ($urandom_range(0, 29) == 0) d1 = int'($urandom_range(0, 15));
        if ($urandom_range(0, 999) == 0) mid_reset();
        step($urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 32) == 0,
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30))
                                         : int'($urandom_range(0, (1 << PTR_W) - 1)),
             lim, d0, d1);
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/scroll_ptr_unit.md
# scroll_ptr_unit

Parametrised multi-layer frame-pointer generator for the background scroll path. It holds one scroll pointer per layer and advances each layer once every N frame ticks, so layers can scroll at different speeds for parallax. Each pointer wraps at a run-time limit, and the block supports a synchronous load for level restarts. It sits between the vsync/frame-tick logic and the background address generators, and is the generalised successor to the single-layer frame-pointer register.

## Interface
Parameters:
- PTR_W, 13, width of each layer's frame pointer
- LAYERS, 2, number of independently scrolled layers
- DIV_W, 4, width of each layer's frame divisor

Ports:
- Clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-low reset (0 = reset)
- ScrollEnable  input  1  global scroll enable; 0 freezes all pointers and prescalers
- FrameTick  input  1  one-cycle pulse per frame (vsync)
- Direction  input  1  0 = forward (increment), 1 = reverse (decrement); honoured only with SCROLL_REVERSE_EN
- LayerDiv  input  LAYERS*DIV_W  per-layer divisor; layer i is at [i*DIV_W +: DIV_W] and advances once every LayerDiv_i+1 ticks
- PtrLimit  input  PTR_W  last valid pointer value (wrap point)
- Load  input  1  synchronous load strobe for all layers
- LoadValue  input  PTR_W  value loaded into all pointers
- FramePtr  output  LAYERS*PTR_W  registered pointers; layer i is at [i*PTR_W +: PTR_W]
- Wrap  output  LAYERS  per-layer one-cycle wrap pulse

## Operation
- **Per-layer state:**
  - pointer ptr_i, PTR_W bits
  - prescaler cnt_i, DIV_W bits
- **Update priority (highest first):** Reset, Load, tick, hold.
- **Load = 1:**
  - ptr_i <= min(LoadValue, PtrLimit) for every layer.
  - cnt_i <= 0.
  - Wrap <= 0.
  - A FrameTick in the same cycle is ignored.
- **Tick:** FrameTick = 1 and ScrollEnable = 1 and Load = 0. For each layer:
  - If cnt_i >= LayerDiv_i: cnt_i <= 0 and ptr_i advances. The >= comparison covers a divisor lowered mid-count.
  - Otherwise cnt_i <= cnt_i + 1 and ptr_i holds.
- **Forward advance:**
  - If ptr_i >= PtrLimit: ptr_i <= 0 and Wrap[i] = 1.
  - Otherwise ptr_i <= ptr_i + 1.
- **Reverse advance:**
  - If ptr_i == 0 or ptr_i > PtrLimit: ptr_i <= PtrLimit and Wrap[i] = 1.
  - Otherwise ptr_i <= ptr_i - 1.
- **Hold:** when ScrollEnable = 0 or FrameTick = 0, pointers and prescalers hold and Wrap = 0.
- **PtrLimit = 0:**
  - Each advance leaves the pointer at 0 and pulses Wrap.
- **Arithmetic:**
  - All arithmetic is unsigned at PTR_W / DIV_W width.
  - No intermediate value exceeds PTR_W bits; the wrap compare is done before the increment.
- **Layer independence:** layers share ScrollEnable, FrameTick, Direction, PtrLimit and Load. Divisors are independent.

## Timing
- **Reset:**
  - Asserting Reset (low) immediately forces every ptr_i = 0, cnt_i = 0 and Wrap = 0, with no clock edge needed.
  - This also applies when Reset asserts mid-run.
- **After Reset deasserts:** a FrameTick on the first rising edge is honoured.
- **Latency:** FramePtr and Wrap change on the rising edge where FrameTick is sampled high. That is 1-cycle latency from the tick.
- **Wrap:**
  - Registered and high for exactly one Clk cycle, aligned with the wrapped FramePtr value.
  - Back-to-back FrameTicks give back-to-back updates; no minimum tick spacing is required.
- **Run-time inputs:** Direction, LayerDiv and PtrLimit are sampled on the same edge as FrameTick. Changes take effect on the next tick.

## Configuration
- **SCROLL_REVERSE_EN defined:**
  - Direction selects forward or reverse advance as described above.
- **SCROLL_REVERSE_EN undefined:**
  - Direction is ignored and every advance is forward.
  - No decrement or reverse-wrap logic is synthesised.

## Test plan
All scenarios use PTR_W=13, LAYERS=2, DIV_W=4, PtrLimit=9 unless stated.
- **Forward wrap:** LayerDiv = {0,0}, 12 ticks -> layer 0 reads 1..9, 0, 1, 2; Wrap[0] pulses once on the 10th tick, aligned with FramePtr = 0.
- **Parallax:** layer 0 div = 0, layer 1 div = 3, PtrLimit = 100, 8 ticks -> FramePtr layer 0 = 8, layer 1 = 2.
- **Freeze:** ScrollEnable = 0 for 5 ticks -> pointers and prescalers unchanged. ScrollEnable = 1 then 1 tick -> layer 0 advances by exactly 1.
- **Load:**
  - Load with LoadValue = 20 coincident with FrameTick -> both pointers = 9, prescalers 0, Wrap = 0.
  - Load with LoadValue = 5 -> both pointers = 5.
- **Reverse (SCROLL_REVERSE_EN defined):**
  - ptr = 0, Direction = 1, tick -> ptr = 9 with a Wrap pulse.
  - Next tick -> ptr = 8.
  - With the macro undefined, the same stimulus gives ptr = 1.
- **Async reset:** after 30 ticks, drive Reset low midway between edges -> FramePtr = 0 and Wrap = 0 before the next Clk edge. After release, the first tick gives layer 0 = 1.
